// File: rtl/exc_ctrl.sv
// Exception controller for the single-cycle LEGv8 core: IRQ synchroniser, ELR/ESR capture,
// PC redirect on entry/return, and halt on double fault or handler watchdog expiry.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal execution; any EStatus or ERET enters the handler
// HANDLER | exception handler running; IRQ masked, watchdog counting
// HALT    | double fault or watchdog expiry; held until reset
module exc_ctrl #(
   parameter int N           = 64,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ExtIRQ_in,
   input  logic [3:0]   EStatus,
   input  logic         ERet,
   input  logic [N-1:0] PC,
   output logic         ExtIRQ,
   output logic         Exc,
   output logic         ERetTaken,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         InHandler,
   output logic         ExtIAck,
   output logic         Halt,
   output logic [7:0]   ExcCount
);

   localparam int WW = $clog2(WDOG_CYCLES) + 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALT    = 2'd2
   } state_t;

   state_t        state;
   logic          s1, s2;
   logic [WW-1:0] wdog_cnt;
   logic          fault;
   logic          wdog_expire;

   assign fault     = (EStatus != 4'd0);
   assign InHandler = (state == ST_HANDLER);
   assign Halt      = (state == ST_HALT);
   assign ExtIRQ    = s2 && (state == ST_RUN);

   // Exc is gated by reset so the decoder sees no redirect while the core is held.
   always_comb begin
      Exc         = 1'b0;
      ERetTaken   = 1'b0;
      wdog_expire = 1'b0;
      case (state)
         ST_RUN:     Exc = reset && (fault || ERet);
         ST_HANDLER: begin
            ERetTaken   = ERet && !fault;
            wdog_expire = (WDOG_CYCLES != 0) && (wdog_cnt == WDOG_LAST) && !fault && !ERet;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_RUN;
         s1       <= 1'b0;
         s2       <= 1'b0;
         ELR      <= '0;
         ESR      <= 4'd0;
         ExcCount <= 8'd0;
         wdog_cnt <= '0;
         ExtIAck  <= 1'b0;
      end else begin
         s1      <= ExtIRQ_in;
         s2      <= s1;
         ExtIAck <= 1'b0;
         case (state)
            ST_RUN: begin
               if (Exc) begin
                  ELR      <= PC;
                  ESR      <= fault ? EStatus : 4'b0011;
                  wdog_cnt <= '0;
                  ExtIAck  <= (EStatus == 4'd1);
                  state    <= ST_HANDLER;
                  if (ExcCount != 8'hFF) ExcCount <= ExcCount + 8'd1;
               end
            end
            ST_HANDLER: begin
               // A fault inside the handler outranks a simultaneous ERET.
               if (fault) begin
                  ELR   <= PC;
                  ESR   <= 4'b1000;
                  state <= ST_HALT;
               end else if (ERetTaken) begin
                  state <= ST_RUN;
               end else if (wdog_expire) begin
                  ELR   <= PC;
                  ESR   <= 4'b1001;
                  state <= ST_HALT;
               end else if (WDOG_CYCLES != 0) begin
                  wdog_cnt <= wdog_cnt + WW'(1);
               end
            end
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random stimulus, every cycle compared
// against a behavioural model of the exception rules.
module tb_exc_ctrl;
   localparam int N  = 64;
   localparam int WD = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         ExtIRQ_in = 1'b0;
   logic [3:0]   EStatus = 4'd0;
   logic         ERet = 1'b0;
   logic [N-1:0] PC = '0;
   logic         ExtIRQ, Exc, ERetTaken, InHandler, ExtIAck, Halt;
   logic [N-1:0] ELR;
   logic [3:0]   ESR;
   logic [7:0]   ExcCount;

   exc_ctrl #(.N(N), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .reset(reset), .ExtIRQ_in(ExtIRQ_in), .EStatus(EStatus), .ERet(ERet),
      .PC(PC), .ExtIRQ(ExtIRQ), .Exc(Exc), .ERetTaken(ERetTaken), .ELR(ELR), .ESR(ESR),
      .InHandler(InHandler), .ExtIAck(ExtIAck), .Halt(Halt), .ExcCount(ExcCount)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // model: mode 0 = running, 1 = in handler, 2 = halted
   int          m_mode, m_cnt, m_hcyc;
   logic [63:0] m_elr;
   logic [3:0]  m_esr;
   bit          m_iack;
   bit          irq_q[$];   // raw IRQ samples, newest first

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_hcyc = 0; m_elr = '0; m_esr = '0; m_iack = 0;
      irq_q.delete();
   endtask

   function automatic bit m_sync();
      return (irq_q.size() >= 2) ? irq_q[1] : 1'b0;
   endfunction

   task automatic compare_all();
      bit run, hnd;
      run = reset && (m_mode == 0);
      hnd = reset && (m_mode == 1);
      chk("Exc",       64'(Exc),       64'(run && (EStatus != 0 || ERet)));
      chk("ERetTaken", 64'(ERetTaken), 64'(hnd && ERet && EStatus == 0));
      chk("ExtIRQ",    64'(ExtIRQ),    64'(run && m_sync()));
      chk("InHandler", 64'(InHandler), 64'(m_mode == 1));
      chk("Halt",      64'(Halt),      64'(m_mode == 2));
      chk("ELR",       ELR,            m_elr);
      chk("ESR",       64'(ESR),       64'(m_esr));
      chk("ExcCount",  64'(ExcCount),  64'(m_cnt));
      chk("ExtIAck",   64'(ExtIAck),   64'(m_iack));
   endtask

   task automatic model_update();
      bit nxt_iack;
      nxt_iack = 0;
      if (!reset) return;
      irq_q.push_front(ExtIRQ_in);
      if (irq_q.size() > 2) void'(irq_q.pop_back());
      case (m_mode)
         0: if (EStatus != 0 || ERet) begin
               m_elr = PC;
               m_esr = (EStatus != 0) ? EStatus : 4'd3;
               if (m_cnt < 255) m_cnt++;
               m_hcyc = 0;
               nxt_iack = (EStatus == 4'd1);
               m_mode = 1;
            end
         1: if (EStatus != 0) begin
               m_elr = PC; m_esr = 4'd8; m_mode = 2;
            end else if (ERet) begin
               m_mode = 0;
            end else if (m_hcyc == WD - 1) begin
               m_elr = PC; m_esr = 4'd9; m_mode = 2;
            end else begin
               m_hcyc++;
            end
         default: ;
      endcase
      m_iack = nxt_iack;
   endtask

   // Called at a falling edge: drive, check, clock, advance model.
   task automatic step(input logic [3:0] es, input logic er, input logic [63:0] pc, input logic irq);
      EStatus = es; ERet = er; PC = pc; ExtIRQ_in = irq;
      #1;
      compare_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      bit irq;
      model_reset();
      // held in reset with a pending fault and IRQ: everything quiet
      ExtIRQ_in = 1'b1; EStatus = 4'b0010;
      repeat (3) @(negedge clk);
      compare_all();
      chk("rst_exc", 64'(Exc), 64'd0);
      reset = 1'b1;

      // invalid opcode straight out of reset
      step(4'b0010, 1'b0, 64'h40, 1'b1);
      chk("inv_elr", ELR, 64'h40);
      chk("inv_esr", 64'(ESR), 64'h2);
      chk("inv_inh", 64'(InHandler), 64'd1);
      chk("inv_ack", 64'(ExtIAck), 64'd0);
      chk("inv_cnt", 64'(ExcCount), 64'd1);
      step(4'b0000, 1'b1, 64'h44, 1'b0);

      // synchroniser latency: ExtIRQ visible two edges after the raw line rises
      do_reset();
      step(4'd0, 1'b0, 64'h0, 1'b1);
      step(4'd0, 1'b0, 64'h4, 1'b1);
      EStatus = 4'd0; #1;
      chk("irq_lat", 64'(ExtIRQ), 64'd1);

      // external IRQ with decoder emulation, held high through the handler
      do_reset();
      step(4'd0, 1'b0, 64'hF0, 1'b1);
      step(4'd0, 1'b0, 64'hF4, 1'b1);
      step(m_sync() ? 4'd1 : 4'd0, 1'b0, 64'h100, 1'b1);
      chk("irq_esr", 64'(ESR), 64'h1);
      chk("irq_elr", ELR, 64'h100);
      chk("irq_ack", 64'(ExtIAck), 64'd1);
      repeat (4) step(4'd0, 1'b0, 64'h200, 1'b1);
      chk("irq_ack1", 64'(ExtIAck), 64'd0);
      step(4'd0, 1'b1, 64'h210, 1'b1);
      EStatus = m_sync() ? 4'd1 : 4'd0; ERet = 1'b0; #1;
      chk("irq_reent", 64'(Exc), 64'd1);
      step(EStatus, 1'b0, 64'h104, 1'b1);
      step(4'd0, 1'b1, 64'h214, 1'b0);

      // spurious ERET in RUN
      do_reset();
      step(4'd0, 1'b1, 64'h20, 1'b0);
      chk("sp_esr", 64'(ESR), 64'h3);
      chk("sp_elr", ELR, 64'h20);

      // double fault with simultaneous ERET, then held under random stimulus
      step(4'b0010, 1'b1, 64'h208, 1'b0);
      chk("df_halt", 64'(Halt), 64'd1);
      chk("df_esr", 64'(ESR), 64'h8);
      chk("df_elr", ELR, 64'h208);
      repeat (20) step(4'($urandom_range(0, 2)), 1'($urandom), {$urandom, $urandom}, 1'($urandom));
      chk("df_hold", 64'(Halt), 64'd1);

      // watchdog expiry after WD idle handler cycles
      do_reset();
      step(4'b0010, 1'b0, 64'h300, 1'b0);
      repeat (WD) step(4'd0, 1'b0, 64'h400, 1'b0);
      chk("wd_halt", 64'(Halt), 64'd1);
      chk("wd_esr", 64'(ESR), 64'h9);

      // return in the final watchdog cycle wins
      do_reset();
      step(4'b0010, 1'b0, 64'h300, 1'b0);
      repeat (WD - 1) step(4'd0, 1'b0, 64'h400, 1'b0);
      step(4'd0, 1'b1, 64'h440, 1'b0);
      chk("wd_ret_halt", 64'(Halt), 64'd0);
      chk("wd_ret_inh", 64'(InHandler), 64'd0);

      // async reset mid-handler takes effect before the next edge
      step(4'b0010, 1'b0, 64'h500, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("ar_inh", 64'(InHandler), 64'd0);
      chk("ar_elr", ELR, 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // entry counter saturation
      for (int i = 0; i < 300; i++) begin
         step(4'b0010, 1'b0, 64'(i), 1'b0);
         step(4'd0, 1'b1, 64'h600, 1'b0);
      end
      chk("cnt_sat", 64'(ExcCount), 64'd255);

      // random stimulus against the model
      do_reset();
      irq = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         int r;
         if ($urandom_range(0, 9) == 0) irq = ~irq;
         r = $urandom_range(0, 99);
         step((r < 75) ? 4'd0 : (r < 88) ? 4'd1 : 4'd2,
              1'($urandom_range(0, 4) == 0), {$urandom, $urandom}, irq);
         if (m_mode == 2 && $urandom_range(0, 4) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
